// File: rtl/tau_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM states,
// flag bit positions and the writeback classification of each opcode.
package tau_pkg;

  typedef enum logic [3:0] {
    NOP         = 4'd0,
    MOV         = 4'd1,
    CMP         = 4'd2,
    TEST        = 4'd3,
    SHFT_L      = 4'd4,
    SHFT_R      = 4'd5,
    ADD         = 4'd6,
    ADC         = 4'd7,
    SUB         = 4'd8,
    SBB         = 4'd9,
    MUL         = 4'd10,
    AND         = 4'd11,
    OR          = 4'd12,
    XOR         = 4'd13,
    NOT         = 4'd14,
    CLEAR_FLAGS = 4'd15
  } alu_op_set;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } ctrl_state_e;

  // Bit positions inside the ALU's 8-bit flags output.
  localparam int FLAG_Z = 7;
  localparam int FLAG_S = 6;
  localparam int FLAG_C = 5;
  localparam int FLAG_O = 4;

  // MOV and the arithmetic/logic group SHFT_L..NOT update the destination.
  function automatic logic op_writes_back(alu_op_set op);
    return (op == MOV) || ((op >= SHFT_L) && (op <= NOT));
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: result on output_C, {Z,S,C,O} on flags[7:4].
// C is carry-out for additions, borrow for subtractions, last bit out for shifts.
module alu
  import tau_pkg::*;
#(
  parameter int WORD_SIZE = 8
) (
  input  logic [WORD_SIZE-1:0] input_A,
  input  logic [WORD_SIZE-1:0] input_B,
  input  alu_op_set            mode_select,
  input  logic                 carry_in,
  output logic [WORD_SIZE-1:0] output_C,
  output logic [7:0]           flags
);

  localparam int W = WORD_SIZE;

  logic [W:0]     wide;
  logic [W:0]     shl;
  logic [W:0]     shr;
  logic [2*W-1:0] prod;
  logic           c;
  logic           o;
  logic           cin_add;
  logic           cin_sub;

  assign cin_add = (mode_select == ADC) & carry_in;
  assign cin_sub = (mode_select == SBB) & carry_in;

  always_comb begin
    wide     = '0;
    c        = 1'b0;
    o        = 1'b0;
    output_C = '0;
    shl      = {1'b0, input_A} << input_B;
    shr      = {input_A, 1'b0} >> input_B;
    prod     = {{W{1'b0}}, input_A} * {{W{1'b0}}, input_B};
    case (mode_select)
      MOV:  output_C = input_B;
      TEST, AND: output_C = input_A & input_B;
      OR:   output_C = input_A | input_B;
      XOR:  output_C = input_A ^ input_B;
      NOT:  output_C = ~input_A;
      CMP, SUB, SBB: begin
        wide     = {1'b0, input_A} - {1'b0, input_B} - {{W{1'b0}}, cin_sub};
        output_C = wide[W-1:0];
        c        = wide[W];
        o        = (input_A[W-1] != input_B[W-1]) && (output_C[W-1] != input_A[W-1]);
      end
      ADD, ADC: begin
        wide     = {1'b0, input_A} + {1'b0, input_B} + {{W{1'b0}}, cin_add};
        output_C = wide[W-1:0];
        c        = wide[W];
        o        = (input_A[W-1] == input_B[W-1]) && (output_C[W-1] != input_A[W-1]);
      end
      SHFT_L: begin
        output_C = shl[W-1:0];
        c        = shl[W];
      end
      SHFT_R: begin
        output_C = shr[W:1];
        c        = shr[0];
      end
      MUL: begin
        output_C = prod[W-1:0];
        c        = |prod[2*W-1:W];
        o        = |prod[2*W-1:W];
      end
      default: output_C = '0;
    endcase
    flags         = '0;
    flags[FLAG_Z] = ~|output_C;
    flags[FLAG_S] = output_C[W-1];
    flags[FLAG_C] = c;
    flags[FLAG_O] = o;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction at a time, reads a 4-entry register
// file, runs the ALU for one cycle, writes back and pulses result_valid.
module alu_issue_ctrl
  import tau_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REGS  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [3:0]           instr_op,
  input  logic [1:0]           instr_rd,
  input  logic [1:0]           instr_rs,
  input  logic                 instr_imm_en,
  input  logic [WORD_SIZE-1:0] instr_imm,
  output logic                 result_valid,
  output logic [WORD_SIZE-1:0] result_data,
  output logic [3:0]           result_flags,
  input  logic [1:0]           dbg_sel,
  output logic [WORD_SIZE-1:0] dbg_data
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready is high exactly while the FSM is IDLE.

  localparam int FLAGS_C_BIT = FLAG_C - FLAG_O;

  ctrl_state_e          state_q;
  alu_op_set            op_q;
  logic [1:0]           rd_q;
  logic [1:0]           rs_q;
  logic                 imm_en_q;
  logic [WORD_SIZE-1:0] imm_q;
  logic [WORD_SIZE-1:0] opa_q;
  logic [WORD_SIZE-1:0] opb_q;
  logic [WORD_SIZE-1:0] res_q;
  logic [3:0]           flags_q;
  logic                 result_valid_q;
  logic [WORD_SIZE-1:0] regs_q [NUM_REGS];

  logic                 in_exec;
  logic [WORD_SIZE-1:0] alu_a;
  logic [WORD_SIZE-1:0] alu_b;
  alu_op_set            alu_mode;
  logic [WORD_SIZE-1:0] alu_out;
  logic [7:0]           alu_flags;
  logic                 unused_alu_flags;

  // The ALU sees live operands only during EXEC and idles on NOP otherwise.
  assign in_exec  = (state_q == EXEC);
  assign alu_a    = in_exec ? opa_q : '0;
  assign alu_b    = in_exec ? opb_q : '0;
  assign alu_mode = in_exec ? op_q : NOP;

  alu #(
    .WORD_SIZE (WORD_SIZE)
  ) u_alu (
    .input_A     (alu_a),
    .input_B     (alu_b),
    .mode_select (alu_mode),
    .carry_in    (flags_q[FLAGS_C_BIT]),
    .output_C    (alu_out),
    .flags       (alu_flags)
  );

  assign unused_alu_flags = ^alu_flags[FLAG_O-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      op_q           <= NOP;
      rd_q           <= '0;
      rs_q           <= '0;
      imm_en_q       <= 1'b0;
      imm_q          <= '0;
      opa_q          <= '0;
      opb_q          <= '0;
      res_q          <= '0;
      flags_q        <= '0;
      result_valid_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            op_q     <= alu_op_set'(instr_op);
            rd_q     <= instr_rd;
            rs_q     <= instr_rs;
            imm_en_q <= instr_imm_en;
            imm_q    <= instr_imm;
            state_q  <= READ;
          end
        end
        READ: begin
          opa_q   <= regs_q[rd_q];
          opb_q   <= imm_en_q ? imm_q : regs_q[rs_q];
          state_q <= EXEC;
        end
        EXEC: begin
          res_q <= alu_out;
          if (op_q == CLEAR_FLAGS) begin
            flags_q <= '0;
          end else if (op_q != NOP) begin
            flags_q <= alu_flags[FLAG_Z:FLAG_O];
          end
          result_valid_q <= 1'b1;
          state_q        <= WRITE;
        end
        WRITE: begin
          if (op_writes_back(op_q)) begin
            regs_q[rd_q] <= res_q;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready  = (state_q == IDLE);
  assign result_valid = result_valid_q;
  assign result_data  = res_q;
  assign result_flags = flags_q;
  assign dbg_data     = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, reset and back-to-back
// sequences, then random instructions against an arithmetic reference model.
module tb_alu_issue_ctrl;
  import tau_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         instr_valid;
  logic         instr_ready;
  logic [3:0]   instr_op;
  logic [1:0]   instr_rd;
  logic [1:0]   instr_rs;
  logic         instr_imm_en;
  logic [W-1:0] instr_imm;
  logic         result_valid;
  logic [W-1:0] result_data;
  logic [3:0]   result_flags;
  logic [1:0]   dbg_sel;
  logic [W-1:0] dbg_data;

  alu_issue_ctrl #(.WORD_SIZE(W), .NUM_REGS(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_rd     (instr_rd),
    .instr_rs     (instr_rs),
    .instr_imm_en (instr_imm_en),
    .instr_imm    (instr_imm),
    .result_valid (result_valid),
    .result_data  (result_data),
    .result_flags (result_flags),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  int regs_m [4];
  int flags_m;

  logic [W-1:0] exp_q [$];

  typedef struct {
    int op; int rd; int rs; int ie; int imm;
    int chk_d; int d; int f; int r;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) regs_m[i] = 0;
    flags_m = 0;
  endtask

  // Reference model: plain integer arithmetic on the architectural state.
  task automatic model_step(input int op, input int rd, input int rs, input int ie,
                            input int imm, output int d, output int f);
    int a, b, cin, r, c, o, t, sa, sb, ts, z, s;
    a   = regs_m[rd];
    b   = ie ? imm : regs_m[rs];
    cin = (flags_m >> 1) & 1;
    sa  = (a > 127) ? a - 256 : a;
    sb  = (b > 127) ? b - 256 : b;
    r = 0; c = 0; o = 0; ts = 0;
    case (op)
      1: r = b;
      2, 8, 9: begin
        t  = a - b - ((op == 9) ? cin : 0);
        ts = sa - sb - ((op == 9) ? cin : 0);
        r  = t & 255;
        c  = (t < 0) ? 1 : 0;
        o  = (ts < -128 || ts > 127) ? 1 : 0;
      end
      3, 11: r = a & b;
      12: r = a | b;
      13: r = a ^ b;
      14: r = (~a) & 255;
      4: begin
        if (b >= 1 && b <= 8) c = (a >> (8 - b)) & 1;
        r = (b >= 8) ? 0 : ((a << b) & 255);
      end
      5: begin
        if (b >= 1 && b <= 8) c = (a >> (b - 1)) & 1;
        r = (b >= 8) ? 0 : (a >> b);
      end
      6, 7: begin
        t  = a + b + ((op == 7) ? cin : 0);
        ts = sa + sb + ((op == 7) ? cin : 0);
        r  = t & 255;
        c  = (t > 255) ? 1 : 0;
        o  = (ts < -128 || ts > 127) ? 1 : 0;
      end
      10: begin
        t = a * b;
        r = t & 255;
        c = (t > 255) ? 1 : 0;
        o = c;
      end
      default: r = 0;
    endcase
    z = (r == 0) ? 1 : 0;
    s = (r >> 7) & 1;
    if (op == 15) flags_m = 0;
    else if (op != 0) flags_m = z * 8 + s * 4 + c * 2 + o;
    if (op == 1 || (op >= 4 && op <= 14)) regs_m[rd] = r;
    d = r;
    f = flags_m;
  endtask

  // ---------------- driver ----------------
  task automatic issue(input int op, input int rd, input int rs, input int ie,
                       input int imm, output int d, output int f);
    int n;
    int cyc;
    int busy_ready;
    n = 0;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_before_issue", int'(instr_ready), 1);
    instr_valid  = 1'b1;
    instr_op     = 4'(op);
    instr_rd     = 2'(rd);
    instr_rs     = 2'(rs);
    instr_imm_en = 1'(ie);
    instr_imm    = 8'(imm);
    tick();
    instr_valid  = 1'b0;
    instr_op     = 4'($urandom);
    instr_rd     = 2'($urandom);
    instr_rs     = 2'($urandom);
    instr_imm_en = 1'($urandom);
    instr_imm    = 8'($urandom);
    cyc = 1;
    busy_ready = 0;
    while (!result_valid && cyc < 12) begin
      if (instr_ready) busy_ready = 1;
      tick();
      cyc++;
    end
    if (instr_ready) busy_ready = 1;
    check("result_latency", cyc, 3);
    check("ready_low_while_busy", busy_ready, 0);
    d = int'(result_data);
    f = int'(result_flags);
    tick();
    check("valid_one_cycle", int'(result_valid), 0);
    check("ready_cycle4", int'(instr_ready), 1);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), int'(dbg_data), regs_m[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d, f, md, mf, idx, cyc, rdy, saw_valid;
    int acc_cyc [$];
    int bb_op [3];
    int bb_imm [3];

    tbl[0]  = '{int'(MOV),         0, 0, 1, 10,  1, 10,  4'b0000, 10};
    tbl[1]  = '{int'(MOV),         1, 0, 1, 30,  1, 30,  4'b0000, 30};
    tbl[2]  = '{int'(ADD),         0, 1, 0, 0,   1, 40,  4'b0000, 40};
    tbl[3]  = '{int'(MOV),         2, 0, 1, 255, 1, 255, 4'b0100, 255};
    tbl[4]  = '{int'(ADD),         2, 0, 1, 1,   1, 0,   4'b1010, 0};
    tbl[5]  = '{int'(ADC),         3, 0, 1, 1,   1, 2,   4'b0000, 2};
    tbl[6]  = '{int'(MOV),         0, 0, 1, 3,   1, 3,   4'b0000, 3};
    tbl[7]  = '{int'(CMP),         0, 0, 1, 4,   1, 255, 4'b0110, 3};
    tbl[8]  = '{int'(CLEAR_FLAGS), 0, 0, 0, 0,   0, 0,   4'b0000, 3};
    tbl[9]  = '{int'(MOV),         1, 0, 1, 2,   1, 2,   4'b0000, 2};
    tbl[10] = '{int'(SHFT_L),      1, 0, 1, 6,   1, 128, 4'b0100, 128};
    tbl[11] = '{int'(SHFT_L),      1, 0, 1, 1,   1, 0,   4'b1010, 0};

    reset_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs = '0;
    instr_imm_en = 1'b0; instr_imm = '0; dbg_sel = '0;
    model_reset();
    tick();
    tick();
    check("rst_ready", int'(instr_ready), 1);
    check("rst_valid", int'(result_valid), 0);
    check("rst_data", int'(result_data), 0);
    check("rst_flags", int'(result_flags), 0);
    reset_n = 1'b1;
    check_regs("rst");

    // Reset while ADD r0,#5 is in EXEC: nothing may complete or write back.
    instr_valid = 1'b1; instr_op = 4'(ADD); instr_rd = 2'd0; instr_rs = 2'd0;
    instr_imm_en = 1'b1; instr_imm = 8'd5;
    tick();
    instr_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_ready", int'(instr_ready), 1);
    check("midrst_valid", int'(result_valid), 0);
    check("midrst_data", int'(result_data), 0);
    check("midrst_flags", int'(result_flags), 0);
    saw_valid = 0;
    for (int i = 0; i < 6; i++) begin
      if (result_valid) saw_valid = 1;
      tick();
    end
    check("midrst_no_pulse", saw_valid, 0);
    model_reset();
    check_regs("midrst");

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      model_step(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].ie, tbl[i].imm, md, mf);
      issue(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].ie, tbl[i].imm, d, f);
      if (tbl[i].chk_d != 0) check($sformatf("tbl%0d_data", i), d, tbl[i].d);
      check($sformatf("tbl%0d_flags", i), f, tbl[i].f);
      dbg_sel = 2'(tbl[i].rd);
      #1;
      check($sformatf("tbl%0d_reg", i), int'(dbg_data), tbl[i].r);
    end
    check_regs("tbl_end");

    // Back-to-back with instr_valid held high: accepts on cycles 0, 4, 8.
    bb_op[0] = int'(MOV); bb_imm[0] = 7;
    bb_op[1] = int'(ADD); bb_imm[1] = 8;
    bb_op[2] = int'(XOR); bb_imm[2] = 255;
    idx = 0;
    cyc = 0;
    while (cyc < 16) begin
      if (idx < 3) begin
        instr_valid = 1'b1; instr_op = 4'(bb_op[idx]); instr_rd = 2'd1;
        instr_rs = 2'd0; instr_imm_en = 1'b1; instr_imm = 8'(bb_imm[idx]);
      end else begin
        instr_valid = 1'b0;
      end
      rdy = int'(instr_ready);
      tick();
      if (rdy != 0 && idx < 3) begin
        acc_cyc.push_back(cyc);
        model_step(bb_op[idx], 1, 0, 1, bb_imm[idx], md, mf);
        exp_q.push_back(W'(md));
        idx++;
      end
      cyc++;
      if (result_valid) begin
        if (exp_q.size() == 0) check("bb_extra_result", 1, 0);
        else check("bb_data", int'(result_data), int'(exp_q.pop_front()));
      end
    end
    instr_valid = 1'b0;
    check("bb_accept_count", acc_cyc.size(), 3);
    for (int i = 0; i < acc_cyc.size(); i++) check($sformatf("bb_accept%0d_cycle", i), acc_cyc[i], 4 * i);
    check("bb_missing_results", exp_q.size(), 0);
    check_regs("bb");

    // Random instructions against the model.
    for (int k = 0; k < 60; k++) begin
      int op, rd, rs, ie, imm;
      op  = $urandom_range(0, 15);
      rd  = $urandom_range(0, 3);
      rs  = $urandom_range(0, 3);
      ie  = $urandom_range(0, 1);
      imm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 255);
      repeat ($urandom_range(0, 2)) tick();
      model_step(op, rd, rs, ie, imm, md, mf);
      issue(op, rd, rs, ie, imm, d, f);
      if (op != 0 && op != 15) check($sformatf("rnd%0d_data_op%0d", k, op), d, md);
      check($sformatf("rnd%0d_flags_op%0d", k, op), f, mf);
      check_regs($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
